// File: rtl/lsu_dcache_port_arbiter_if.sv
// Bundle of requester-side and dcache-side signals of the LSU dcache port
// arbiter. The arbiter takes the slave view; the surrounding LSU/cache takes
// the master view.
interface lsu_dcache_port_arbiter_if #(
  parameter int NR_PORTS   = 3,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  // requester side (one slice per port)
  logic [NR_PORTS-1:0]            req;
  logic [NR_PORTS-1:0]            we;
  logic [NR_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NR_PORTS*DATA_WIDTH-1:0] wdata;
  logic [NR_PORTS*BE_WIDTH-1:0]   be;
  logic [NR_PORTS-1:0]            gnt;
  logic [NR_PORTS-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]          rdata;

  // dcache side
  logic                           cache_req;
  logic                           cache_we;
  logic [ADDR_WIDTH-1:0]          cache_addr;
  logic [DATA_WIDTH-1:0]          cache_wdata;
  logic [BE_WIDTH-1:0]            cache_be;
  logic                           cache_gnt;
  logic                           cache_rvalid;
  logic [DATA_WIDTH-1:0]          cache_rdata;

  // status
  logic                           busy;

  modport slave (
    input  req, we, addr, wdata, be,
    input  cache_gnt, cache_rvalid, cache_rdata,
    output gnt, rvalid, rdata,
    output cache_req, cache_we, cache_addr, cache_wdata, cache_be,
    output busy
  );

  modport master (
    output req, we, addr, wdata, be,
    output cache_gnt, cache_rvalid, cache_rdata,
    input  gnt, rvalid, rdata,
    input  cache_req, cache_we, cache_addr, cache_wdata, cache_be,
    input  busy
  );
endinterface

// File: rtl/lsu_dcache_port_arbiter.sv
// Round-robin arbiter sharing one dcache request port between NR_PORTS LSU
// requesters (store drain, load unit, AMO). One transaction in flight: the
// winner's request is latched, held on the cache port until granted, and for
// reads the response is routed back to the same winner.
module lsu_dcache_port_arbiter #(
  parameter int NR_PORTS   = 3,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  lsu_dcache_port_arbiter_if.slave bus
);

  localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]        idx_reg, idx_next;
  logic                    we_reg, we_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [BE_WIDTH-1:0]     be_reg, be_next;

  // per-port views of the flattened request fields
  logic [ADDR_WIDTH-1:0]   port_addr  [NR_PORTS];
  logic [DATA_WIDTH-1:0]   port_wdata [NR_PORTS];
  logic [BE_WIDTH-1:0]     port_be    [NR_PORTS];

  // candidate port at each priority offset from rr_ptr, and whether it requests
  logic [PTR_W-1:0]        cand_idx   [NR_PORTS];
  logic [NR_PORTS-1:0]     cand_valid;

  logic                    pick_valid;
  logic [PTR_W-1:0]        pick_idx;
  logic [PTR_W-1:0]        idx_plus_one;

  logic [NR_PORTS-1:0]     gnt_vec;
  logic [NR_PORTS-1:0]     rvalid_vec;
  logic [DATA_WIDTH-1:0]   rdata_val;

  generate
    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
      // rr_ptr < NR_PORTS and gi < NR_PORTS, so one conditional subtract wraps
      logic [PTR_W:0] sum;
      assign sum           = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
      assign cand_idx[gi]  = (sum >= (PTR_W+1)'(NR_PORTS)) ?
                             PTR_W'(sum - (PTR_W+1)'(NR_PORTS)) : PTR_W'(sum);
      assign cand_valid[gi] = bus.req[cand_idx[gi]];

      assign port_addr[gi]  = bus.addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign port_wdata[gi] = bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign port_be[gi]    = bus.be[gi*BE_WIDTH +: BE_WIDTH];
    end
  endgenerate

  // Priority pick: lowest offset from rr_ptr wins (scan from the far end so
  // the nearest requester overwrites).
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int o = NR_PORTS - 1; o >= 0; o--) begin
      if (cand_valid[o]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[o];
      end
    end
  end

  // The granted port drops to lowest priority for the next arbitration.
  assign idx_plus_one = (idx_reg == PTR_W'(NR_PORTS - 1)) ? '0 : idx_reg + PTR_W'(1);

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      idx_reg    <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      be_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      idx_reg    <= idx_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      be_reg     <= be_next;
    end
  end

  // Next-state: arbitrate and latch in IDLE, wait for grant in REQ, wait for
  // the read response in WAIT. Requester inputs are only sampled in IDLE.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    idx_next    = idx_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    be_next     = be_reg;
    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = REQ;
          idx_next   = pick_idx;
          we_next    = bus.we[pick_idx];
          addr_next  = port_addr[pick_idx];
          wdata_next = port_wdata[pick_idx];
          be_next    = port_be[pick_idx];
        end
      end
      REQ: begin
        if (bus.cache_gnt) begin
          rr_ptr_next = idx_plus_one;
          state_next  = we_reg ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.cache_rvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: grant and response pulses go only to the latched winner;
  // an rvalid outside WAIT (including the grant cycle) is dropped.
  always_comb begin
    gnt_vec    = '0;
    rvalid_vec = '0;
    rdata_val  = '0;
    if (state_reg == REQ && bus.cache_gnt) begin
      gnt_vec[idx_reg] = 1'b1;
    end
    if (state_reg == WAIT && bus.cache_rvalid) begin
      rvalid_vec[idx_reg] = 1'b1;
      rdata_val           = bus.cache_rdata;
    end
  end

  assign bus.gnt         = gnt_vec;
  assign bus.rvalid      = rvalid_vec;
  assign bus.rdata       = rdata_val;
  assign bus.cache_req   = (state_reg == REQ);
  assign bus.cache_we    = we_reg;
  assign bus.cache_addr  = addr_reg;
  assign bus.cache_wdata = wdata_reg;
  assign bus.cache_be    = be_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_lsu_dcache_port_arbiter.sv
// Directed bench for lsu_dcache_port_arbiter. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_lsu_dcache_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 34;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_dcache_port_arbiter_if #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  lsu_dcache_port_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    bus.cache_gnt = 1'b0; bus.cache_rvalid = 1'b0; bus.cache_rdata = '0;
  endtask

  task automatic set_port(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
    bus.we[k] = w;
    bus.addr[k*AW +: AW] = a;
    bus.wdata[k*DW +: DW] = d;
    bus.be[k*BW +: BW] = b;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_ni = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    next_cycle(); #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    n_tests++; if (bus.cache_req !== 1'b0) begin n_fail++; $display("FAIL rst_cache_req: got %b exp 0", bus.cache_req); end
    n_tests++; if ({bus.gnt, bus.rvalid} !== 6'b0) begin n_fail++; $display("FAIL rst_gnt_rvalid: got %b exp 0", {bus.gnt, bus.rvalid}); end
    n_tests++; if ({bus.cache_we, bus.cache_addr, bus.cache_wdata, bus.cache_be, bus.rdata} !== '0) begin n_fail++; $display("FAIL rst_fields: got %h exp 0", {bus.cache_we, bus.cache_addr, bus.cache_wdata, bus.cache_be, bus.rdata}); end
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_port [4] = '{0, 1, 2, 0};
    logic [NP-1:0] eg;
    logic [AW-1:0] ea;
    do_reset();
    for (int k = 0; k < NP; k++) set_port(k, 1'b1, AW'((k + 1) * 256), DW'(k), 4'hF);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.req = 3'b111; bus.cache_gnt = 1'b1;
      #1;
      n_tests++; if (bus.gnt !== 3'b000 || bus.cache_req !== 1'b0) begin n_fail++; $display("FAIL rr_idle_%0d: gnt %b req %b exp 000 0", i, bus.gnt, bus.cache_req); end
      next_cycle(); #1;
      eg = NP'(1 << exp_port[i]);
      ea = AW'((exp_port[i] + 1) * 256);
      n_tests++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b exp %b", i, bus.gnt, eg); end
      n_tests++; if (bus.cache_addr !== ea) begin n_fail++; $display("FAIL rr_addr_%0d: got %h exp %h", i, bus.cache_addr, ea); end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    next_cycle();
    bus.req = 3'b010;
    set_port(1, 1'b1, 34'h0_0000_1A40, 32'hDEADBEEF, 4'hF);
    #1;
    n_tests++; if (bus.cache_req !== 1'b0) begin n_fail++; $display("FAIL wr_req_N: got %b exp 0", bus.cache_req); end
    next_cycle();
    bus.cache_gnt = 1'b1;
    #1;
    n_tests++; if (bus.cache_req !== 1'b1 || bus.cache_we !== 1'b1) begin n_fail++; $display("FAIL wr_req_N1: req %b we %b exp 1 1", bus.cache_req, bus.cache_we); end
    n_tests++; if (bus.cache_addr !== 34'h0_0000_1A40 || bus.cache_wdata !== 32'hDEADBEEF || bus.cache_be !== 4'hF) begin n_fail++; $display("FAIL wr_fields: got %h %h %h exp 0001a40 deadbeef f", bus.cache_addr, bus.cache_wdata, bus.cache_be); end
    n_tests++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL wr_gnt: got %b exp 010", bus.gnt); end
    next_cycle();
    bus.req = '0; bus.cache_gnt = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.cache_req !== 1'b0) begin n_fail++; $display("FAIL wr_back_idle: busy %b req %b exp 0 0", bus.busy, bus.cache_req); end
    // rr_ptr is now 2: with all three requesting, port 2 must win
    next_cycle();
    bus.req = 3'b111;
    for (int k = 0; k < NP; k++) set_port(k, 1'b1, AW'(k + 16), DW'(k), 4'h1);
    next_cycle();
    bus.cache_gnt = 1'b1;
    #1;
    n_tests++; if (bus.gnt !== 3'b100 || bus.cache_addr !== 34'd18) begin n_fail++; $display("FAIL wr_rr_ptr2: gnt %b addr %h exp 100 12", bus.gnt, bus.cache_addr); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_read_delayed();
    next_cycle();
    bus.req = 3'b100;
    set_port(2, 1'b0, 34'h3_0000_0008, 32'h0, 4'hF);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      bus.cache_gnt = (c == 3);
      #1;
      n_tests++; if (bus.cache_req !== 1'b1 || bus.cache_addr !== 34'h3_0000_0008 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rd_hold_%0d: req %b addr %h busy %b exp 1 300000008 1", c, bus.cache_req, bus.cache_addr, bus.busy); end
      n_tests++; if (bus.gnt !== ((c == 3) ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL rd_gnt_%0d: got %b", c, bus.gnt); end
      next_cycle();
    end
    bus.req = '0; bus.cache_gnt = 1'b0;
    #1;
    n_tests++; if (bus.cache_req !== 1'b0 || bus.busy !== 1'b1 || bus.rvalid !== 3'b000) begin n_fail++; $display("FAIL rd_wait: req %b busy %b rvalid %b exp 0 1 000", bus.cache_req, bus.busy, bus.rvalid); end
    next_cycle();
    bus.cache_rvalid = 1'b1; bus.cache_rdata = 32'h12345678;
    #1;
    n_tests++; if (bus.rvalid !== 3'b100 || bus.rdata !== 32'h12345678 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rd_resp: rvalid %b rdata %h busy %b exp 100 12345678 1", bus.rvalid, bus.rdata, bus.busy); end
    next_cycle();
    bus.cache_rvalid = 1'b0;
    #1;
    n_tests++; if (bus.rvalid !== 3'b000 || bus.rdata !== 32'h0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rd_done: rvalid %b rdata %h busy %b exp 000 0 0", bus.rvalid, bus.rdata, bus.busy); end
    bus.cache_rdata = '0;
  endtask

  task automatic test_field_stability();
    next_cycle();
    bus.req = 3'b001;
    set_port(0, 1'b1, 34'h0_0000_0200, 32'h11112222, 4'h3);
    next_cycle();
    set_port(0, 1'b1, 34'h0_0000_03FF, 32'hFFFF0000, 4'hC);
    #1;
    n_tests++; if (bus.cache_addr !== 34'h200 || bus.cache_wdata !== 32'h11112222 || bus.cache_be !== 4'h3) begin n_fail++; $display("FAIL stab_pre: got %h %h %h exp 200 11112222 3", bus.cache_addr, bus.cache_wdata, bus.cache_be); end
    next_cycle();
    set_port(0, 1'b0, 34'h1_2345_6789, 32'h0BADF00D, 4'h0);
    bus.cache_gnt = 1'b1;
    #1;
    n_tests++; if (bus.cache_addr !== 34'h200 || bus.cache_wdata !== 32'h11112222 || bus.cache_we !== 1'b1 || bus.gnt !== 3'b001) begin n_fail++; $display("FAIL stab_gnt: addr %h wdata %h we %b gnt %b exp 200 11112222 1 001", bus.cache_addr, bus.cache_wdata, bus.cache_we, bus.gnt); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_stray_rvalid();
    next_cycle();
    bus.cache_rvalid = 1'b1; bus.cache_rdata = 32'hAAAA5555;
    #1;
    n_tests++; if (bus.rvalid !== 3'b000 || bus.rdata !== 32'h0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL stray_idle: rvalid %b rdata %h busy %b exp 000 0 0", bus.rvalid, bus.rdata, bus.busy); end
    bus.req = 3'b010;
    set_port(1, 1'b1, 34'h55, 32'h66, 4'hF);
    next_cycle();
    bus.cache_gnt = 1'b1;
    #1;
    n_tests++; if (bus.gnt !== 3'b010 || bus.rvalid !== 3'b000 || bus.rdata !== 32'h0) begin n_fail++; $display("FAIL stray_gnt_cycle: gnt %b rvalid %b rdata %h exp 010 000 0", bus.gnt, bus.rvalid, bus.rdata); end
    next_cycle();
    bus.req = '0; bus.cache_gnt = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.rvalid !== 3'b000) begin n_fail++; $display("FAIL stray_after: busy %b rvalid %b exp 0 000", bus.busy, bus.rvalid); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    next_cycle();
    bus.req = 3'b010;
    set_port(1, 1'b0, 34'h2_0000_0040, 32'h0, 4'hF);
    next_cycle();
    bus.cache_gnt = 1'b1;
    #1;
    n_tests++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL rw_gnt: got %b exp 010", bus.gnt); end
    next_cycle();
    bus.req = '0; bus.cache_gnt = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rw_in_wait: busy %b exp 1", bus.busy); end
    rst_ni = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.cache_req !== 1'b0 || bus.cache_addr !== '0 || bus.cache_be !== '0) begin n_fail++; $display("FAIL rw_async: busy %b req %b addr %h be %h exp 0 0 0 0", bus.busy, bus.cache_req, bus.cache_addr, bus.cache_be); end
    next_cycle();
    rst_ni = 1'b1;
    bus.cache_rvalid = 1'b1; bus.cache_rdata = 32'hCAFEF00D;
    #1;
    n_tests++; if (bus.rvalid !== 3'b000 || bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rw_no_rvalid: rvalid %b rdata %h exp 000 0", bus.rvalid, bus.rdata); end
    next_cycle();
    #1;
    n_tests++; if (bus.rvalid !== 3'b000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rw_no_rvalid2: rvalid %b busy %b exp 000 0", bus.rvalid, bus.busy); end
    bus.cache_rvalid = 1'b0;
    bus.req = 3'b011;
    set_port(0, 1'b1, 34'h0_0000_0A00, 32'h1, 4'hF);
    set_port(1, 1'b1, 34'h0_0000_0B00, 32'h2, 4'hF);
    bus.cache_gnt = 1'b1;
    next_cycle();
    #1;
    n_tests++; if (bus.gnt !== 3'b001 || bus.cache_addr !== 34'hA00) begin n_fail++; $display("FAIL rw_next_port0: gnt %b addr %h exp 001 a00", bus.gnt, bus.cache_addr); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_single_write();
    test_read_delayed();
    test_field_stability();
    test_stray_rvalid();
    test_reset_in_wait();
    next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
